sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-to-one arbiter that shares the single SRAM-like memory port between the instruction-fetch requester and the data requester. The data requester is the memory-stage load/store path. The block sits between the pipeline's inst/data SRAM-like interfaces and the top-level memory bridge. It grants one requester at a time and latches that requester's address, size, write strobe and data. It keeps exactly one transaction outstanding downstream and routes the `addr_ok`/`data_ok`/`rdata` response back to the owner. The pipeline sees per-requester handshakes only and builds its stall requests from them.

## Interface
- No parameters; address and data widths are fixed at 32.
- `clk`  in  1  — system clock; all state changes on the rising edge.
- `resetn`  in  1  — synchronous, active-low reset.
- `inst_req`, `data_req`  in  1  — request valid; held by the requester until its `*_addr_ok`.
- `inst_wr`, `data_wr`  in  1  — 1 = write, 0 = read.
- `inst_size`, `data_size`  in  2  — 0 = byte, 1 = half, 2 = word.
- `inst_wstrb`, `data_wstrb`  in  4  — byte write enables; ignored on reads.
- `inst_addr`, `data_addr`  in  32  — byte address.
- `inst_wdata`, `data_wdata`  in  32  — write data.
- `inst_addr_ok`, `data_addr_ok`  out  1  — 1-cycle pulse: request accepted.
- `inst_data_ok`, `data_data_ok`  out  1  — 1-cycle pulse: transaction complete.
- `inst_rdata`, `data_rdata`  out  32  — read data, valid with `*_data_ok`.
- `m_req`, `m_wr`, `m_size[1:0]`, `m_wstrb[3:0]`, `m_addr[31:0]`, `m_wdata[31:0]`  out  — shared downstream request; all driven from registers.
- `m_addr_ok`, `m_data_ok`  in  1  — downstream handshake pulses.
- `m_rdata`  in  32  — downstream read data.
- `owner_data`  out  1  — 1 while the current or last transaction belongs to the data requester.
- `proto_err`  out  1  — sticky flag: downstream protocol violation seen.

## Operation
- FSM states:
  - IDLE: no transaction.
  - ADDR: `m_req` high, waiting for `m_addr_ok`.
  - DATA: waiting for `m_data_ok`.
- IDLE, any `*_req` high: arbitrate, latch the winner's `wr`/`size`/`wstrb`/`addr`/`wdata` and owner, go to ADDR.
- ADDR, `m_addr_ok` = 1:
  - pulse the owner's `*_addr_ok` in the same cycle (combinational from `m_addr_ok` and the owner register);
  - go to DATA.
- DATA, `m_data_ok` = 1:
  - pulse the owner's `*_data_ok` in the same cycle; owner's `*_rdata` = `m_rdata` (combinational);
  - if any `*_req` is high that cycle, arbitrate and go straight to ADDR (back-to-back); otherwise go to IDLE.
- Arbitration (default): data has fixed priority over inst.
- The non-owner never receives `addr_ok`/`data_ok`.
- Non-owner `*_rdata` = 0; owner `*_rdata` = 0 when `m_data_ok` = 0.
- Requester inputs change only under the requester's own handshake rule. The latched copy is authoritative from the ADDR entry edge onward.
- `proto_err` is set on any of:
  - `m_data_ok` outside DATA;
  - `m_addr_ok` outside ADDR.
- The offending pulse is otherwise ignored. `proto_err` is cleared only by reset.

## Timing
- Reset (`resetn` = 0 at an edge) forces:
  - state IDLE;
  - `m_req` = 0, `m_wr` = 0, `m_size` = 0, `m_wstrb` = 0, `m_addr` = 0, `m_wdata` = 0;
  - `owner_data` = 0, `proto_err` = 0, round-robin last-grant = inst.
- All `*_addr_ok`, `*_data_ok` and `*_rdata` outputs read 0 during reset.
- Reset in ADDR or DATA abandons the transaction: no `data_ok` pulse follows.
- Request to `m_req`: 1 cycle from IDLE; 0 extra cycles when chained from DATA.
- Minimum transaction with a zero-wait downstream (`addr_ok` in the first ADDR cycle, `data_ok` the next cycle): 2 cycles in chained mode, 3 from IDLE.
- `m_addr_ok` and `m_data_ok` in the same cycle while in ADDR: `addr_ok` is honoured, `data_ok` sets `proto_err`, state goes to DATA.
- Both requests rise in the same cycle: one grant per arbitration; the loser stays pending and is served on the next arbitration.

## Configuration
- `ARB_RR_EN` undefined: fixed priority, data always wins ties.
- `ARB_RR_EN` defined: round robin.
  - On a tie, the requester not granted most recently wins.
  - A lone requester always wins.
  - Last-grant updates on every grant and resets to inst, so the first tie after reset goes to data.

## Test plan
- Reset: hold `resetn` = 0 for 3 cycles with both requests high -> `m_req` = 0, all `*_ok` = 0, `proto_err` = 0; first `m_req` appears 1 cycle after reset release.
- Single inst read at 0xBFC00000, word, downstream zero-wait with `m_rdata` = 0x24080001 -> `inst_addr_ok` then `inst_data_ok` with `inst_rdata` = 0x24080001; `data_*_ok` stay 0.
- Tie, fixed priority: both requests held for 3 transactions -> grants data, data, data while `data_req` stays high; inst served only after `data_req` drops.
- Tie, `ARB_RR_EN`: both held continuously -> grants data, inst, data, inst, back-to-back with no IDLE cycle between them.
- Data store at 0x80001003, byte, `wstrb` = 4'b1000, `wdata` = 0xAB000000, with 3 wait cycles before `m_addr_ok` -> `m_*` fields stable for all 4 ADDR cycles, `data_addr_ok` on the 4th.
- Protocol error: pulse `m_data_ok` in IDLE -> `proto_err` = 1 and stays set; no requester `data_ok`; the next normal transaction completes correctly.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-to-one SRAM-like port arbiter: inst fetch vs. data path, one txn in flight.
// Define ARB_RR_EN for round-robin ties; default build gives data fixed priority.
module sram_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        owner_data,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;
  logic   any_req;
  logic   arb;
  logic   pick_data;
  logic   hit_a;
  logic   hit_d;

  assign any_req = inst_req | data_req;
  assign arb = any_req &
    ((state == IDLE) | ((state == DATA) & m_data_ok));

`ifdef ARB_RR_EN
  logic last_data;

  // On a tie the requester not granted most recently wins.
  assign pick_data = data_req & (~inst_req | ~last_data);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_data <= 1'b0;
    end else if (arb) begin
      last_data <= pick_data;
    end
  end
`else
  assign pick_data = data_req;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      m_req      <= 1'b0;
      m_wr       <= 1'b0;
      m_size     <= 2'd0;
      m_wstrb    <= 4'd0;
      m_addr     <= 32'd0;
      m_wdata    <= 32'd0;
      owner_data <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if ((m_data_ok && state != DATA) ||
          (m_addr_ok && state != ADDR)) begin
        proto_err <= 1'b1;
      end
      if (arb) begin
        owner_data <= pick_data;
        m_wr    <= pick_data ? data_wr    : inst_wr;
        m_size  <= pick_data ? data_size  : inst_size;
        m_wstrb <= pick_data ? data_wstrb : inst_wstrb;
        m_addr  <= pick_data ? data_addr  : inst_addr;
        m_wdata <= pick_data ? data_wdata : inst_wdata;
      end
      unique case (state)
        IDLE: begin
          if (arb) begin
            state <= ADDR;
            m_req <= 1'b1;
          end
        end
        ADDR: begin
          if (m_addr_ok) begin
            state <= DATA;
            m_req <= 1'b0;
          end
        end
        DATA: begin
          if (m_data_ok) begin
            state <= arb ? ADDR : IDLE;
            m_req <= arb;
          end
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

  assign hit_a = resetn & (state == ADDR) & m_addr_ok;
  assign hit_d = resetn & (state == DATA) & m_data_ok;

  assign inst_addr_ok = hit_a & ~owner_data;
  assign data_addr_ok = hit_a & owner_data;
  assign inst_data_ok = hit_d & ~owner_data;
  assign data_data_ok = hit_d & owner_data;
  assign inst_rdata   = inst_data_ok ? m_rdata : 32'd0;
  assign data_rdata   = data_data_ok ? m_rdata : 32'd0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus random traffic.
// Index 0 is the inst requester, index 1 the data requester.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req [2];
  logic        wr [2];
  logic [1:0]  size [2];
  logic [3:0]  wstrb [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        m_addr_ok = 1'b0;
  logic        m_data_ok = 1'b0;
  logic [31:0] m_rdata = 32'd0;

  logic        inst_addr_ok, inst_data_ok;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        owner_data, proto_err;

  logic [1:0]  aok, dok;
  logic [31:0] rd [2];
  logic [70:0] mf;

  int n_cmp = 0;
  int n_err = 0;
  int last = 0;

  assign aok = {data_addr_ok, inst_addr_ok};
  assign dok = {data_data_ok, inst_data_ok};
  assign rd[0] = inst_rdata;
  assign rd[1] = data_rdata;
  assign mf = {m_wr, m_size, m_wstrb, m_addr, m_wdata};

  sram_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(req[0]), .inst_wr(wr[0]), .inst_size(size[0]),
    .inst_wstrb(wstrb[0]), .inst_addr(addr[0]), .inst_wdata(wdata[0]),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(req[1]), .data_wr(wr[1]), .data_size(size[1]),
    .data_wstrb(wstrb[1]), .data_addr(addr[1]), .data_wdata(wdata[1]),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .owner_data(owner_data), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Arbitration rule: 1 = data wins.
  function automatic int pick(logic pi, logic pd);
`ifdef ARB_RR_EN
    if (pi && pd) return (last == 0) ? 1 : 0;
`endif
    if (pd) return 1;
    return 0;
  endfunction

  task automatic new_req(input int who);
    req[who]   = 1'b1;
    wr[who]    = 1'($urandom);
    size[who]  = 2'($urandom_range(0, 2));
    wstrb[who] = 4'($urandom);
    addr[who]  = $urandom;
    wdata[who] = $urandom;
  endtask

  task automatic do_reset;
    @(negedge clk);
    resetn = 1'b0;
    req[0] = 1'b0;
    req[1] = 1'b0;
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    last = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    resetn = 1'b0;
    new_req(0);
    new_req(1);
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (m_req !== 1'b0) begin
        n_err++; $display("FAIL rst_m_req got %b want 0", m_req);
      end
      n_cmp++;
      if ({aok, dok} !== 4'b0) begin
        n_err++; $display("FAIL rst_ok got %b want 0000", {aok, dok});
      end
      n_cmp++;
      if ({proto_err, owner_data} !== 2'b0) begin
        n_err++;
        $display("FAIL rst_flags got %b want 00", {proto_err, owner_data});
      end
      n_cmp++;
      if (mf !== 71'd0) begin
        n_err++; $display("FAIL rst_fields got %h want 0", mf);
      end
    end
    resetn = 1'b1;
    last = 0;
    @(negedge clk);
    n_cmp++;
    if ({m_req, owner_data} !== 2'b11) begin
      n_err++;
      $display("FAIL rst_first_req got %b want 11", {m_req, owner_data});
    end
    n_cmp++;
    if (m_addr !== addr[1]) begin
      n_err++; $display("FAIL rst_first_addr got %h want %h", m_addr, addr[1]);
    end
    resetn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_req !== 1'b0) begin
      n_err++; $display("FAIL rst_abandon got %b want 0", m_req);
    end
  endtask

  task automatic test_inst_read;
    do_reset;
    req[0] = 1'b1; wr[0] = 1'b0; size[0] = 2'd2; wstrb[0] = 4'd0;
    addr[0] = 32'hBFC00000; wdata[0] = 32'd0;
    @(negedge clk);
    n_cmp++;
    if ({m_req, owner_data, m_addr} !== {2'b10, 32'hBFC00000}) begin
      n_err++;
      $display("FAIL ird_req got %b%b %h want 10 bfc00000",
               m_req, owner_data, m_addr);
    end
    m_addr_ok = 1'b1;
    #1;
    n_cmp++;
    if (aok !== 2'b01) begin
      n_err++; $display("FAIL ird_addr_ok got %b want 01", aok);
    end
    @(negedge clk);
    m_addr_ok = 1'b0;
    req[0] = 1'b0;
    m_data_ok = 1'b1;
    m_rdata = 32'h24080001;
    #1;
    n_cmp++;
    if (dok !== 2'b01) begin
      n_err++; $display("FAIL ird_data_ok got %b want 01", dok);
    end
    n_cmp++;
    if ({rd[0], rd[1]} !== {32'h24080001, 32'd0}) begin
      n_err++;
      $display("FAIL ird_rdata got %h/%h want 24080001/0", rd[0], rd[1]);
    end
    @(negedge clk);
    m_data_ok = 1'b0;
    n_cmp++;
    if ({m_req, proto_err} !== 2'b00) begin
      n_err++; $display("FAIL ird_end got %b want 00", {m_req, proto_err});
    end
  endtask

  task automatic test_tie;
    int w;
    do_reset;
    new_req(0);
    new_req(1);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      m_data_ok = 1'b0;
      w = pick(req[0], req[1]);
      last = w;
      n_cmp++;
      if ({m_req, owner_data} !== {1'b1, w[0]}) begin
        n_err++;
        $display("FAIL tie_grant%0d got %b%b want 1%0d", t, m_req, owner_data, w);
      end
      m_addr_ok = 1'b1;
      #1;
      n_cmp++;
      if (aok !== (w == 1 ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL tie_aok%0d got %b owner %0d", t, aok, w);
      end
      @(negedge clk);
      m_addr_ok = 1'b0;
      m_data_ok = 1'b1;
      m_rdata = $urandom;
      if (t == 3) req[1] = 1'b0;
      if (t == 4) req[0] = 1'b0;
      #1;
      n_cmp++;
      if (dok !== (w == 1 ? 2'b10 : 2'b01) || rd[w] !== m_rdata) begin
        n_err++;
        $display("FAIL tie_dok%0d got %b %h want owner %0d %h",
                 t, dok, rd[w], w, m_rdata);
      end
    end
    @(negedge clk);
    m_data_ok = 1'b0;
    n_cmp++;
    if (m_req !== 1'b0) begin
      n_err++; $display("FAIL tie_idle got %b want 0", m_req);
    end
  endtask

  task automatic test_store_wait;
    logic [70:0] ef;
    do_reset;
    req[1] = 1'b1; wr[1] = 1'b1; size[1] = 2'd0; wstrb[1] = 4'b1000;
    addr[1] = 32'h80001003; wdata[1] = 32'hAB000000;
    ef = {1'b1, 2'd0, 4'b1000, 32'h80001003, 32'hAB000000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) m_addr_ok = 1'b1;
      #1;
      n_cmp++;
      if ({m_req, mf} !== {1'b1, ef}) begin
        n_err++;
        $display("FAIL st_fields%0d got %b %h want 1 %h", i, m_req, mf, ef);
      end
      n_cmp++;
      if (aok !== (i == 3 ? 2'b10 : 2'b00)) begin
        n_err++; $display("FAIL st_aok%0d got %b", i, aok);
      end
    end
    @(negedge clk);
    m_addr_ok = 1'b0;
    req[1] = 1'b0;
    m_data_ok = 1'b1;
    m_rdata = 32'd0;
    #1;
    n_cmp++;
    if (dok !== 2'b10) begin
      n_err++; $display("FAIL st_dok got %b want 10", dok);
    end
    @(negedge clk);
    m_data_ok = 1'b0;
  endtask

  task automatic test_proto_err;
    do_reset;
    m_data_ok = 1'b1;
    #1;
    n_cmp++;
    if (dok !== 2'b00) begin
      n_err++; $display("FAIL pe_idle_dok got %b want 00", dok);
    end
    @(negedge clk);
    m_data_ok = 1'b0;
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_err++; $display("FAIL pe_set got %b want 1", proto_err);
    end
    req[0] = 1'b1; wr[0] = 1'b0; size[0] = 2'd2; addr[0] = $urandom;
    @(negedge clk);
    m_addr_ok = 1'b1;
    #1;
    n_cmp++;
    if ({m_req, aok} !== 3'b101) begin
      n_err++; $display("FAIL pe_next_aok got %b want 101", {m_req, aok});
    end
    @(negedge clk);
    m_addr_ok = 1'b0;
    req[0] = 1'b0;
    m_data_ok = 1'b1;
    m_rdata = $urandom;
    #1;
    n_cmp++;
    if (dok !== 2'b01 || rd[0] !== m_rdata) begin
      n_err++;
      $display("FAIL pe_next_dok got %b %h want 01 %h", dok, rd[0], m_rdata);
    end
    @(negedge clk);
    m_data_ok = 1'b0;
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_err++; $display("FAIL pe_sticky got %b want 1", proto_err);
    end
    do_reset;
    n_cmp++;
    if (proto_err !== 1'b0) begin
      n_err++; $display("FAIL pe_clear got %b want 0", proto_err);
    end
    req[1] = 1'b1; wr[1] = 1'b0; size[1] = 2'd2; addr[1] = $urandom;
    @(negedge clk);
    m_addr_ok = 1'b1;
    m_data_ok = 1'b1;
    #1;
    n_cmp++;
    if ({aok, dok} !== 4'b1000) begin
      n_err++; $display("FAIL pe_both got %b want 1000", {aok, dok});
    end
    @(negedge clk);
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    req[1] = 1'b0;
    n_cmp++;
    if ({proto_err, m_req} !== 2'b10) begin
      n_err++; $display("FAIL pe_both_flag got %b want 10", {proto_err, m_req});
    end
    m_data_ok = 1'b1;
    #1;
    n_cmp++;
    if (dok !== 2'b10) begin
      n_err++; $display("FAIL pe_both_dok got %b want 10", dok);
    end
    @(negedge clk);
    m_data_ok = 1'b0;
  endtask

  task automatic test_random(input int n);
    int w, wa, wd, msk;
    bit chained;
    logic pi, pd;
    logic [70:0] ef;
    do_reset;
    chained = 1'b0;
    pi = 1'b0;
    pd = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      m_data_ok = 1'b0;
      if (!chained) begin
        n_cmp++;
        if (m_req !== 1'b0) begin
          n_err++; $display("FAIL rnd_idle%0d got %b want 0", k, m_req);
        end
        msk = $urandom_range(1, 3);
        if (msk[0]) new_req(0);
        if (msk[1]) new_req(1);
        pi = req[0];
        pd = req[1];
        @(negedge clk);
      end
      w = pick(pi, pd);
      last = w;
      n_cmp++;
      if ({m_req, owner_data} !== {1'b1, w[0]}) begin
        n_err++;
        $display("FAIL rnd_grant%0d got %b%b want 1%0d", k, m_req, owner_data, w);
      end
      ef = {wr[w], size[w], wstrb[w], addr[w], wdata[w]};
      wa = $urandom_range(0, 3);
      for (int i = 0; i <= wa; i++) begin
        if (i == wa) m_addr_ok = 1'b1;
        #1;
        n_cmp++;
        if (mf !== ef) begin
          n_err++; $display("FAIL rnd_fields%0d got %h want %h", k, mf, ef);
        end
        n_cmp++;
        if (aok !== (i != wa ? 2'b00 : (w == 1 ? 2'b10 : 2'b01))) begin
          n_err++; $display("FAIL rnd_aok%0d got %b owner %0d", k, aok, w);
        end
        @(negedge clk);
      end
      m_addr_ok = 1'b0;
      req[w] = 1'b0;
      wd = $urandom_range(0, 3);
      for (int i = 0; i < wd; i++) begin
        #1;
        n_cmp++;
        if ({m_req, dok} !== 3'b000) begin
          n_err++; $display("FAIL rnd_wait%0d got %b want 000", k, {m_req, dok});
        end
        @(negedge clk);
      end
      m_data_ok = 1'b1;
      m_rdata = $urandom;
      if (!req[0] && ($urandom % 2) == 1) new_req(0);
      if (!req[1] && ($urandom % 2) == 1) new_req(1);
      pi = req[0];
      pd = req[1];
      chained = pi | pd;
      #1;
      n_cmp++;
      if (dok !== (w == 1 ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL rnd_dok%0d got %b owner %0d", k, dok, w);
      end
      n_cmp++;
      if (rd[w] !== m_rdata || rd[1 - w] !== 32'd0) begin
        n_err++;
        $display("FAIL rnd_rdata%0d got %h/%h want %h/0",
                 k, rd[w], rd[1 - w], m_rdata);
      end
    end
    @(negedge clk);
    m_data_ok = 1'b0;
    n_cmp++;
    if (proto_err !== 1'b0) begin
      n_err++; $display("FAIL rnd_proto got %b want 0", proto_err);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; size[i] = 2'd0;
      wstrb[i] = 4'd0; addr[i] = 32'd0; wdata[i] = 32'd0;
    end
    test_reset;
    test_inst_read;
    test_tie;
    test_store_wait;
    test_proto_err;
    test_random(60);
    $display("random traffic done, last grant to %0d", last);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
